// File: rtl/vga_tile_renderer.sv
// Pixel-colour stage for a 1024x768 VGA timing driver.
// Looks up a COLS x ROWS grid of square tiles in an internal tile RAM. It can
// draw a grid overlay and a blinking cursor over the tiles. The output is
// 12-bit RGB, and the sync pulses are delayed to line up with the colour.
//
// Write port: a single-cycle strobe with no back-pressure. Every cycle with
// wr_en=1 is one write. Only addresses below COLS*ROWS are stored; any other
// address is dropped. A read of the address being written in the same cycle
// returns the old contents.
module vga_tile_renderer #(
  parameter int          TILE_LOG2    = 5,
  parameter int          COLS         = 32,
  parameter int          ROWS         = 24,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] GRID_COLOR   = 12'h444
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [10:0] hc_visible,
  input  logic [10:0] vc_visible,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [9:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        cursor_en,
  input  logic [4:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        grid_en,
  output logic        hs_out,
  output logic        vs_out,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam logic [11:0] X_LIMIT    = 12'(COLS << TILE_LOG2);
  localparam logic [11:0] Y_LIMIT    = 12'(ROWS << TILE_LOG2);
  localparam logic [10:0] TILE_LIMIT = 11'(COLS * ROWS);
  localparam int          CW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  // Fixed 16-entry palette.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] c;
    case (idx)
      4'd0:    c = 12'h000;
      4'd1:    c = 12'hF00;
      4'd2:    c = 12'h0F0;
      4'd3:    c = 12'h00F;
      4'd4:    c = 12'hFF0;
      4'd5:    c = 12'h0FF;
      4'd6:    c = 12'hF0F;
      4'd7:    c = 12'h888;
      4'd8:    c = 12'h800;
      4'd9:    c = 12'h080;
      4'd10:   c = 12'h008;
      4'd11:   c = 12'h880;
      4'd12:   c = 12'h088;
      4'd13:   c = 12'h808;
      4'd14:   c = 12'h444;
      default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  logic [10:0] x, y, col, row;
  logic        active_c, grid_c, cursor_c;
  logic [9:0]  rd_addr;

  logic [3:0]  tile_mem [0:1023];
  logic [3:0]  ram_q;
  logic        s1_active, s1_grid, s1_cursor;
  logic        hs_d1, vs_d1;
  logic        vs_prev;
  logic [CW-1:0] frame_cnt;
  logic        blink_phase;
  logic [11:0] base_color, pix_color;

  // Decode pixel coordinates into tile position, overlay hits and RAM address.
  always_comb begin
    x        = hc_visible - 11'd1;
    y        = vc_visible - 11'd1;
    col      = x >> TILE_LOG2;
    row      = y >> TILE_LOG2;
    active_c = (hc_visible != 11'd0) && (vc_visible != 11'd0) &&
               ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
    grid_c   = grid_en && ((x[TILE_LOG2-1:0] == '0) || (y[TILE_LOG2-1:0] == '0));
    cursor_c = cursor_en && (col == 11'(cursor_col)) && (row == 11'(cursor_row));
    rd_addr  = 10'(row * 11'(COLS) + col);
  end

  // Host-side tile RAM writes; contents are deliberately not reset.
  always_ff @(posedge clk_vga) begin
    if (wr_en && ({1'b0, wr_addr} < TILE_LIMIT)) begin
      tile_mem[wr_addr] <= wr_data;
    end
  end

  // Synchronous tile read; sees pre-write data on a same-address collision.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      ram_q <= '0;
    end else begin
      ram_q <= tile_mem[rd_addr];
    end
  end

  // Stage 1: register the pixel flags and the first sync delay tap.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      s1_active <= 1'b0;
      s1_grid   <= 1'b0;
      s1_cursor <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
    end else begin
      s1_active <= active_c;
      s1_grid   <= grid_c;
      s1_cursor <= cursor_c;
      hs_d1     <= hs_in;
      vs_d1     <= vs_in;
    end
  end

  // Stage 2 colour: grid beats tile, cursor inverts during the on phase.
  always_comb begin
    base_color = s1_grid ? GRID_COLOR : palette(ram_q);
    pix_color  = (s1_cursor && blink_phase) ? ~base_color : base_color;
    if (!s1_active) begin
      pix_color = 12'h000;
    end
  end

  // Stage 2: register colour and the second sync delay tap together.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      rgb    <= 12'h000;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else begin
      rgb    <= pix_color;
      hs_out <= hs_d1;
      vs_out <= vs_d1;
    end
  end

  // Registered frame tick on each falling edge of vsync.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      vs_prev    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= vs_in;
      frame_tick <= vs_prev && !vs_in;
    end
  end

  // Count frame ticks; every BLINK_FRAMES ticks flip the cursor phase.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Pixel-colour stage placed directly downstream of the 1024x768 VGA timing driver.
- Consumes the driver's visible-pixel coordinates and sync pulses, and looks up a 32x24 grid of 32x32-pixel tiles held in an internal tile RAM.
- Applies an optional grid overlay and a blinking cursor.
- Emits 12-bit RGB with sync re-aligned to the pipelined colour. The tile RAM is written by a host-side port at any time.

Parameters:
- TILE_LOG2, 5, log2 of tile edge in pixels
- COLS, 32, tiles per row
- ROWS, 24, tile rows
- BLINK_FRAMES, 30, frames per cursor blink half-period (must be ≥1)
- GRID_COLOR, 12'h444, grid line colour

Ports:
- clk_vga  in  1  pixel clock
- rst_n  in  1  synchronous reset, active low
- hc_visible  in  11  visible column + 1; 0 = blanking
- vc_visible  in  11  visible row + 1; 0 = blanking
- hs_in  in  1  driver hsync, active low
- vs_in  in  1  driver vsync, active low
- wr_en  in  1  tile RAM write strobe
- wr_addr  in  10  tile index = row*COLS + col
- wr_data  in  4  palette index
- cursor_en  in  1  cursor enable
- cursor_col  in  5  cursor tile column
- cursor_row  in  5  cursor tile row
- grid_en  in  1  grid overlay enable
- hs_out  out  1  hsync delayed to match rgb
- vs_out  out  1  vsync delayed to match rgb
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- Reset (rst_n=0 at a clk_vga edge):
  - rgb=0, hs_out=1, vs_out=1, frame_tick=0.
  - All pipeline and delay registers are cleared to their inactive values; frame counter=0; blink_phase=0.
  - Tile RAM contents are not reset and are undefined until written.
- Active pixel: hc_visible≠0 AND vc_visible≠0. Then x=hc_visible-1 and y=vc_visible-1 (11-bit unsigned).
  - Pixel is also treated as blank if x ≥ COLS<<TILE_LOG2 or y ≥ ROWS<<TILE_LOG2.
- Tile coordinates: col=x>>TILE_LOG2, row=y>>TILE_LOG2, read address=row*COLS+col.
- Stage 1 (edge N registers the inputs sampled at N):
  - Registers active, the grid hit, and the cursor hit.
  - Grid hit: x[TILE_LOG2-1:0]==0 or y[TILE_LOG2-1:0]==0, qualified by grid_en.
  - Cursor hit: col==cursor_col && row==cursor_row && cursor_en.
  - Issues the synchronous tile RAM read.
- Stage 2 (edge N+1): palette lookup and overlay; result registered to rgb.
- Total latency is 2 cycles from hc_visible/vc_visible to rgb. hs_in/vs_in pass through a matching 2-stage delay to hs_out/vs_out.
- Fixed palette, index:colour:
  - 0:000 1:F00 2:0F0 3:00F 4:FF0 5:0FF 6:F0F 7:888
  - 8:800 9:080 10:008 11:880 12:088 13:808 14:444 15:FFF
- Colour priority:
  - If blank, rgb=0.
  - Otherwise base = grid hit ? GRID_COLOR : palette[tile].
  - rgb = (cursor hit && blink_phase) ? ~base : base.
- Tile RAM:
  - 1024x4; only addresses < COLS*ROWS (768) are writable. Writes with wr_addr ≥768 are ignored.
  - A write takes effect on the clock edge with wr_en=1.
  - When a read and a write hit the same address in the same cycle, the read returns the old data (read-first).
- Frame tick and blink:
  - vs_prev is a register of vs_in.
  - frame_tick=1 for exactly one cycle when vs_prev=1 and vs_in=0 (registered, so it appears 1 cycle after the falling edge is sampled).
  - The frame counter counts frame_ticks from 0 to BLINK_FRAMES-1. On the tick that would reach BLINK_FRAMES, it wraps to 0 and toggles blink_phase.
- Cursor timing: cursor_col/row values ≥COLS/ROWS never match any tile, so no cursor is drawn. Cursor inputs are sampled every cycle with no shadowing; a change mid-frame is allowed to tear.
- Reset mid-frame: outputs go to their reset values on the next edge. Normal operation resumes from whatever coordinates arrive after rst_n returns to 1. The first 2 output cycles after reset are blank (rgb=0).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving active coordinates -> rgb=0, hs_out=vs_out=1, frame_tick=0; release -> first non-zero rgb appears no earlier than 2 cycles after release.
- Latency/alignment: write tile 0=1 (F00); drive hc_visible=5, vc_visible=5 with hs_in pulsing low for 1 cycle at the same time -> rgb=12'hF00 exactly 2 cycles later, coincident with the hs_out low pulse.
- Addressing/bounds: write addr 33=3, addr 767=15, addr 800=2 -> pixel (x=40,y=40) gives 00F; pixel (x=1010,y=760) gives FFF; no pixel ever shows colour 2 from addr 800; hc_visible=0 gives rgb=0.
- Grid: grid_en=1, tile 33=3 -> pixel (x=32,y=40) gives 444; pixel (x=33,y=41) gives 00F.
- Cursor blink: BLINK_FRAMES=2, cursor at (1,1), tile 33=3, generate 6 vs falling edges -> frame_tick pulses 6 times; blink_phase toggles after ticks 2, 4 and 6; pixel (40,40) alternates 00F / FF0 across phases.
- Same-cycle write/read: tile 0 holds 1, rewritten to 2 in the same cycle pixel (0,0) is read -> that pixel shows F00; the next read of tile 0 shows 0F0.
